// File: rtl/trace_recorder_if.sv
// Readout stream of the trace recorder: valid/ready handshake carrying one
// captured entry per beat, with a last-beat marker.
interface trace_recorder_if #(
  parameter int DATA_W = 64
) ();
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/trace_recorder.sv
// Multi-channel trace capture buffer with pre/post-trigger window and streamed readout.
// Optional TRACE_TIMESTAMP_EN stores a 16-bit cycle stamp in the MSBs of each entry.
module trace_recorder #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 16,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_en,
  input  logic [NUM_CH*CH_W-1:0]       ch_data,
  input  logic                         arm,
  input  logic                         trig,
  input  logic                         abort,
  input  logic                         start_rd,
  trace_recorder_if.master             rd,
  output logic [2:0]                   state,
  output logic [$clog2(DEPTH+1)-1:0]   entry_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   trig_pos
);

  localparam int SAMPLE_W = NUM_CH * CH_W;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W     = 16;
  localparam int DW       = SAMPLE_W + TS_W;
`else
  localparam int DW       = SAMPLE_W;
`endif
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int PW       = $clog2(POST_TRIG + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_POST  = 3'd2,
    S_DONE  = 3'd3,
    S_READ  = 3'd4
  } state_e;

  state_e          state_q,     state_d;
  logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]   entry_cnt_q, entry_cnt_d;
  logic [CW-1:0]   trig_pos_q,  trig_pos_d;
  logic [CW-1:0]   remaining_q, remaining_d;
  logic [PW-1:0]   post_cnt_q,  post_cnt_d;
  logic            rd_valid_q,  rd_valid_d;
  logic            rd_last_q,   rd_last_d;
  logic [DW-1:0]   rd_data_q,   rd_data_d;

  logic [DW-1:0]   mem [DEPTH];
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;
  logic            rd_xfer;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  assign ts_d      = ts_q + TS_W'(1);
  assign mem_wdata = {ts_q, ch_data};
`else
  assign mem_wdata = ch_data;
`endif

  assign rd_xfer = rd_valid_q & rd.rd_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    entry_cnt_d = entry_cnt_q;
    trig_pos_d  = trig_pos_q;
    remaining_d = remaining_q;
    post_cnt_d  = post_cnt_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_data_d   = rd_data_q;
    mem_we      = 1'b0;

    if (abort) begin
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            wr_ptr_d    = '0;
            entry_cnt_d = '0;
            post_cnt_d  = '0;
            state_d     = S_ARMED;
          end
        end

        S_ARMED, S_POST: begin
          if (sample_en) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (entry_cnt_q != CW'(DEPTH)) entry_cnt_d = entry_cnt_q + CW'(1);
          end
          // The sample written in the trigger cycle is already post-trigger sample 1.
          if (state_q == S_ARMED) begin
            if (trig) begin
              post_cnt_d = sample_en ? PW'(1) : '0;
              state_d    = S_POST;
            end
          end else if (sample_en) begin
            post_cnt_d = post_cnt_q + PW'(1);
          end
          if (state_d == S_POST && post_cnt_d == PW'(POST_TRIG)) begin
            state_d    = S_DONE;
            trig_pos_d = entry_cnt_d - CW'(POST_TRIG);
          end
        end

        S_DONE: begin
          if (start_rd) begin
            state_d     = S_READ;
            rd_ptr_d    = (entry_cnt_q == CW'(DEPTH)) ? wr_ptr_q : '0;
            remaining_d = entry_cnt_q;
          end
        end

        S_READ: begin
          // Output register refills whenever it is empty or being drained this cycle.
          if (rd_xfer && rd_last_q) begin
            state_d    = S_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end else if ((!rd_valid_q || rd.rd_ready) && remaining_q != '0) begin
            rd_valid_d  = 1'b1;
            rd_data_d   = mem[rd_ptr_q];
            rd_last_d   = (remaining_q == CW'(1));
            rd_ptr_d    = rd_ptr_q + AW'(1);
            remaining_d = remaining_q - CW'(1);
          end else if (rd_xfer) begin
            rd_valid_d = 1'b0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      entry_cnt_q <= '0;
      trig_pos_q  <= '0;
      remaining_q <= '0;
      post_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
`ifdef TRACE_TIMESTAMP_EN
      ts_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      entry_cnt_q <= entry_cnt_d;
      trig_pos_q  <= trig_pos_d;
      remaining_q <= remaining_d;
      post_cnt_q  <= post_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
`ifdef TRACE_TIMESTAMP_EN
      ts_q        <= ts_d;
`endif
    end
  end

  // NOTE: the capture memory has no reset; entry_cnt alone defines which
  // entries are meaningful, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= mem_wdata;
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_last_q;
  assign rd.rd_data  = rd_data_q;
  assign state       = state_q;
  assign entry_cnt   = entry_cnt_q;
  assign trig_pos    = trig_pos_q;

endmodule

// File: tb/tb_trace_recorder.sv
// Directed self-checking bench for trace_recorder (NUM_CH=2, CH_W=8, DEPTH=8, POST_TRIG=4).
// Define TRACE_TIMESTAMP_EN for both RTL and bench to exercise the timestamp option.
module tb_trace_recorder;

  localparam int NUM_CH    = 2;
  localparam int CH_W      = 8;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 4;
  localparam int SW        = NUM_CH * CH_W;
`ifdef TRACE_TIMESTAMP_EN
  localparam int DW        = SW + 16;
`else
  localparam int DW        = SW;
`endif
  localparam int CW        = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          sample_en;
  logic [SW-1:0] ch_data;
  logic          arm;
  logic          trig;
  logic          abort;
  logic          start_rd;
  logic [2:0]    state;
  logic [CW-1:0] entry_cnt;
  logic [CW-1:0] trig_pos;

  int checks = 0;
  int errors = 0;

  trace_recorder_if #(.DATA_W(DW)) rif ();

  trace_recorder #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .ch_data   (ch_data),
    .arm       (arm),
    .trig      (trig),
    .abort     (abort),
    .start_rd  (start_rd),
    .rd        (rif),
    .state     (state),
    .entry_cnt (entry_cnt),
    .trig_pos  (trig_pos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Channel 1 carries n+0x40, channel 0 carries n, so a channel swap shows up.
  function automatic logic [SW-1:0] pat(input int n);
    logic [7:0] lo;
    logic [7:0] hi;
    lo  = 8'(n);
    hi  = 8'(n + 64);
    pat = {hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int n, input bit t);
    sample_en = 1'b1;
    ch_data   = pat(n);
    trig      = t;
    tick();
    sample_en = 1'b0;
    trig      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; sample_en = 1'b0; ch_data = '0; arm = 1'b0; trig = 1'b0;
    abort = 1'b0; start_rd = 1'b0; rif.rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Reads n beats expected to be pat(first .. first+n-1); bp selects the 1,0,0,1 ready pattern.
  task automatic read_all(input int n, input int first, input bit bp);
    int k;
    int cyc;
    int first_valid;
    bit stalled;
    k = 0; cyc = 0; first_valid = -1;
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    check("read_state", 32'(state), 32'd4);
    while (k < n && cyc < 64) begin
      rif.rd_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      stalled = 1'b0;
      if (rif.rd_valid && first_valid < 0) first_valid = cyc;
      if (rif.rd_valid && rif.rd_ready) begin
        check("rd_data", 32'(rif.rd_data[SW-1:0]), 32'(pat(first + k)));
        check("rd_last", 32'(rif.rd_last), 32'(k == n - 1));
        k++;
      end else if (rif.rd_valid) begin
        stalled = 1'b1;
      end
      tick();
      cyc++;
      if (stalled) begin
        check("stall_data", 32'(rif.rd_data[SW-1:0]), 32'(pat(first + k)));
        check("stall_valid", 32'(rif.rd_valid), 32'd1);
        check("stall_last", 32'(rif.rd_last), 32'(k == n - 1));
      end
    end
    rif.rd_ready = 1'b0;
    check("valid_latency", 32'(first_valid >= 0 && first_valid <= 2), 32'd1);
    check("beat_count", 32'(k), 32'(n));
    check("valid_after_last", 32'(rif.rd_valid), 32'd0);
    check("idle_after_last", 32'(state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_entry_cnt", 32'(entry_cnt), 32'd0);
    check("rst_trig_pos", 32'(trig_pos), 32'd0);
    check("rst_rd_valid", 32'(rif.rd_valid), 32'd0);
    check("rst_rd_last", 32'(rif.rd_last), 32'd0);
    check("rst_rd_data", 32'(rif.rd_data), 32'd0);

    // IDLE ignores trig and start_rd.
    trig = 1'b1; start_rd = 1'b1;
    tick();
    trig = 1'b0; start_rd = 1'b0;
    check("idle_ignores_trig", 32'(state), 32'd0);

    // Wrap: 20 samples, trigger with 17, oldest retained is 13.
    arm_pulse();
    check("armed", 32'(state), 32'd1);
    check("arm_clears_cnt", 32'(entry_cnt), 32'd0);
    for (int n = 1; n <= 19; n++) sample(n, n == 17);
    check("wrap_post", 32'(state), 32'd2);
    sample(20, 1'b0);
    check("wrap_done", 32'(state), 32'd3);
    check("wrap_entry_cnt", 32'(entry_cnt), 32'd8);
    check("wrap_trig_pos", 32'(trig_pos), 32'd4);
    arm_pulse();
    check("arm_ignored_done", 32'(state), 32'd3);
    read_all(8, 13, 1'b0);

    // Short fill: trigger with sample 3 of 6.
    arm_pulse();
    for (int n = 1; n <= 5; n++) sample(n, n == 3);
    check("short_post", 32'(state), 32'd2);
    sample(6, 1'b0);
    check("short_done", 32'(state), 32'd3);
    check("short_entry_cnt", 32'(entry_cnt), 32'd6);
    check("short_trig_pos", 32'(trig_pos), 32'd2);
    read_all(6, 1, 1'b0);

    // Gaps in POST with stray trig and data on idle cycles; readout under backpressure.
    arm_pulse();
    for (int n = 1; n <= 6; n++) sample(n, n == 6);
    for (int n = 7; n <= 9; n++) begin
      sample_en = 1'b0; trig = 1'b1; ch_data = pat(99);
      tick();
      trig = 1'b0;
      check("gap_still_post", 32'(state), 32'd2);
      sample(n, 1'b0);
    end
    check("gap_done", 32'(state), 32'd3);
    check("gap_entry_cnt", 32'(entry_cnt), 32'd8);
    check("gap_trig_pos", 32'(trig_pos), 32'd4);
    read_all(8, 2, 1'b1);

    // Asynchronous reset while beat 3 is presented.
    arm_pulse();
    for (int n = 1; n <= 6; n++) sample(n, n == 3);
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    rif.rd_ready = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_beat3", 32'(rif.rd_data[SW-1:0]), 32'(pat(3)));
    rst = 1'b0;
    #2;
    check("async_rst_valid", 32'(rif.rd_valid), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_entry_cnt", 32'(entry_cnt), 32'd0);
    check("async_rst_rd_data", 32'(rif.rd_data), 32'd0);
    rif.rd_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_idle", 32'(state), 32'd0);

    // Abort in POST; a later trigger stays ignored.
    arm_pulse();
    sample(1, 1'b0);
    sample(2, 1'b1);
    check("abort_pre_post", 32'(state), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", 32'(state), 32'd0);
    check("abort_rd_valid", 32'(rif.rd_valid), 32'd0);
    sample(3, 1'b1);
    check("abort_trig_ignored", 32'(state), 32'd0);

    // arm and trig together: ARMED only, trigger not latched.
    arm = 1'b1; trig = 1'b1;
    tick();
    arm = 1'b0; trig = 1'b0;
    check("arm_trig_armed", 32'(state), 32'd1);
    sample(1, 1'b0);
    check("trig_not_latched", 32'(state), 32'd1);
    abort = 1'b1; arm = 1'b1;
    tick();
    check("abort_in_armed", 32'(state), 32'd0);
    tick();
    check("abort_beats_arm", 32'(state), 32'd0);
    abort = 1'b0; arm = 1'b0;

`ifdef TRACE_TIMESTAMP_EN
    // Stamps count rising edges since reset release: samples taken while stamp is 5,6,9,10..13.
    begin
      int stamps [7] = '{5, 6, 9, 10, 11, 12, 13};
      do_reset();
      arm_pulse();
      repeat (4) tick();
      sample(1, 1'b0);
      sample(2, 1'b0);
      tick();
      tick();
      sample(3, 1'b0);
      for (int n = 4; n <= 7; n++) sample(n, n == 4);
      check("ts_done", 32'(state), 32'd3);
      start_rd = 1'b1;
      tick();
      start_rd = 1'b0;
      rif.rd_ready = 1'b1;
      tick();
      for (int k = 0; k < 7; k++) begin
        check("ts_stamp", 32'(rif.rd_data[DW-1 -: 16]), 32'(stamps[k]));
        check("ts_data", 32'(rif.rd_data[SW-1:0]), 32'(pat(k + 1)));
        tick();
      end
      rif.rd_ready = 1'b0;
      check("ts_idle", 32'(state), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_recorder.md
TRACE_RECORDER -- requirements
Module: trace_recorder

Interface
REQ-001 Parameter NUM_CH, default 4, number of traced channels.
REQ-002 Parameter CH_W, default 16, bits per channel.
REQ-003 Parameter DEPTH, default 64, entries in the capture buffer; power of 2, at least 4.
REQ-004 Parameter POST_TRIG, default 32, samples captured after trigger; range 1..DEPTH.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset (rst=0 resets).
REQ-007 sample_en  in  1  qualifies ch_data this cycle (e.g. pipeline_stall_n).
REQ-008 ch_data  in  NUM_CH*CH_W  channel k at bits [k*CH_W +: CH_W].
REQ-009 arm  in  1  start capture (1-cycle pulse).
REQ-010 trig  in  1  trigger event.
REQ-011 abort  in  1  abandon any activity, return to IDLE.
REQ-012 start_rd  in  1  begin readout of captured buffer.
REQ-013 rd_valid  out  1  readout beat valid.
REQ-014 rd_ready  in  1  consumer accepts beat.
REQ-015 rd_data  out  NUM_CH*CH_W (+16 with TRACE_TIMESTAMP_EN, stamp in MSBs)  one entry.
REQ-016 rd_last  out  1  marks final readout beat.
REQ-017 state  out  3  IDLE=0, ARMED=1, POST=2, DONE=3, READ=4.
REQ-018 entry_cnt  out  $clog2(DEPTH+1)  valid entries held.
REQ-019 trig_pos  out  $clog2(DEPTH+1)  pre-trigger entries retained, valid in DONE/READ.

Function
REQ-020 The IDLE state SHALL ignore trig/start_rd and, on arm=1, clear wr_ptr and entry_cnt and enter ARMED next cycle.
REQ-021 ARMED and POST SHALL write ch_data to mem[wr_ptr] on each sample_en=1 cycle, wr_ptr incrementing modulo DEPTH, entry_cnt saturating at DEPTH (oldest overwritten).
REQ-022 The ARMED state SHALL, on trig=1, enter POST with post_cnt=0; a sample written in the trigger cycle counts as post-trigger sample 1.
REQ-023 The POST state SHALL ignore trig, increment post_cnt per written sample, and enter DONE the cycle after post_cnt reaches POST_TRIG; sample_en=0 cycles do not count.
REQ-024 The block SHALL set trig_pos = entry_cnt - POST_TRIG on entry to DONE.
REQ-025 The DONE state SHALL hold the buffer and, on start_rd=1, enter READ with rd_ptr = oldest entry (wr_ptr if entry_cnt==DEPTH, else 0) and remaining=entry_cnt.
REQ-026 The READ state SHALL present entries oldest-first; rd_valid rises no later than 2 cycles after READ entry; a beat transfers on rd_valid&rd_ready.
REQ-027 The block SHALL hold rd_data/rd_last stable while rd_valid=1 and rd_ready=0; back-to-back transfers at 1 beat/cycle when rd_ready held 1.
REQ-028 The block SHALL assert rd_last with the final (entry_cnt-th) beat; after its transfer, rd_valid=0 and state returns to IDLE next cycle.
REQ-029 The block SHALL ignore arm outside IDLE; abort=1 in any state forces IDLE next cycle, rd_valid=0, buffer contents undefined; abort overrides arm when both asserted.
REQ-030 When trig=1 and arm=1 coincide in IDLE, the block SHALL enter ARMED only; trig is not latched.

Reset
REQ-031 While rst=0 the block SHALL set state=IDLE, wr_ptr=0, rd_ptr=0, entry_cnt=0, trig_pos=0, post_cnt=0, rd_valid=0, rd_last=0, rd_data=0, timestamp=0; memory contents need not reset.
REQ-032 Reset asserted mid-capture or mid-readout SHALL take effect immediately (asynchronous); the release SHALL be synchronous to clk.

Configuration
REQ-033 With TRACE_TIMESTAMP_EN defined, the block SHALL keep a 16-bit free-running cycle counter (wraps 0xFFFF->0) and store it with each entry; rd_data is NUM_CH*CH_W+16 wide.
REQ-034 Without TRACE_TIMESTAMP_EN, the block SHALL have no counter or storage for it, and rd_data is NUM_CH*CH_W wide.

Verification (NUM_CH=2, CH_W=8, DEPTH=8, POST_TRIG=4)
REQ-035 Wrap: arm, 20 samples ch_data=n (n=1..20), trig with sample 17 -> DONE; readout 13..20, trig_pos=4, rd_last on beat 8.
REQ-036 Short fill: arm, trig with sample 3 of 6 -> entry_cnt=6, trig_pos=2, readout 1..6.
REQ-037 Gaps: sample_en=0 on alternating cycles in POST -> exactly 4 post samples stored, DONE not before 4th.
REQ-038 Backpressure: rd_ready=1,0,0,1 repeating -> rd_data unchanged while stalled, no beat lost or duplicated.
REQ-039 Reset/abort: rst=0 mid-READ beat 3 -> rd_valid=0, state=IDLE immediately; abort in POST -> IDLE next cycle, later trig ignored.
REQ-040 TRACE_TIMESTAMP_EN: samples on cycles 5,6,9 after reset -> stamps 5,6,9 in rd_data[31:16].
